// File: rtl/rr_arb_pkg.sv
// Shared types and the circular first-set search for the round-robin lock arbiter.
// Contents: arb_state_e (IDLE/BUSY), MaxReq width bound, rr_rotate_first().
package rr_arb_pkg;

  localparam int unsigned MaxReq  = 32;
  localparam int unsigned MaxReqW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // First set index at or after start, wrapping modulo n; returns start when req is empty.
  function automatic int unsigned rr_rotate_first(input logic [MaxReq-1:0] req,
                                                  input int unsigned       start,
                                                  input int unsigned       n);
    int unsigned idx;
    int unsigned res;
    logic        found;
    res   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = start + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[MaxReqW-1:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular picker: first requester at or after start_i, ignoring excl_i.
// Ports: req_i (requests), start_i (search start), excl_i (excluded mask),
//        win_oh_o (one-hot winner), win_idx_o (winner index), any_o (a winner exists).
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   start_i,
  input  logic [NumReq-1:0] excl_i,
  output logic [NumReq-1:0] win_oh_o,
  output logic [IdxW-1:0]   win_idx_o,
  output logic              any_o
);

  logic [NumReq-1:0] masked;
  logic [MaxReq-1:0] req_ext;

  assign masked    = req_i & ~excl_i;
  assign req_ext   = MaxReq'(masked);
  assign any_o     = |masked;
  assign win_idx_o = IdxW'(rr_rotate_first(req_ext, 32'(start_i), NumReq));
  assign win_oh_o  = any_o ? (NumReq'(1) << win_idx_o) : '0;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking: an owner keeps the grant while its request
// stays high; on release the next requester in circular order takes over without a
// dead cycle. Optional hold limit (macro RR_LOCK_ARB_HOLD_LIMIT_EN) forces rotation
// after MaxHold owned cycles when others are waiting.
// Ports: clk, rstN (async active-low), req_in (requests), grant_out (one-hot grant),
//        grant_valid (grant_out non-zero), grant_idx (current/last owner),
//        preempt (one-cycle pulse when the owner loses grant to the hold limit).
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
  parameter int unsigned MaxHold = 16,
`endif
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [NumReq-1:0] req_in,
  output logic [NumReq-1:0] grant_out,
  output logic              grant_valid,
  output logic [IdxW-1:0]   grant_idx,
  output logic              preempt
);

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic              valid_q, valid_d;

  logic [IdxW-1:0]   start;
  logic [NumReq-1:0] win_oh;
  logic [IdxW-1:0]   win_idx;
  logic              win_any;
  logic              owner_req;

  // Search begins just past the most recent owner; the owner itself is always excluded,
  // which only matters while it still requests (hold-limit rotation).
  assign start     = (last_q == IdxW'(NumReq - 1)) ? '0 : IdxW'(last_q + IdxW'(1));
  assign owner_req = req_in[idx_q];

  rr_pick #(.NumReq(NumReq)) u_pick (
    .req_i    (req_in),
    .start_i  (start),
    .excl_i   (grant_q),
    .win_oh_o (win_oh),
    .win_idx_o(win_idx),
    .any_o    (win_any)
  );

`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
  localparam int unsigned CntW = (MaxHold > 1) ? $clog2(MaxHold) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxHold - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            preempt_q, preempt_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IdxW'(NumReq - 1);
      valid_q   <= 1'b0;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      cnt_q     <= '0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
`endif
    end
  end

  // Next-state and grant selection
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BUSY;
          grant_d = win_oh;
          idx_d   = win_idx;
          last_d  = win_idx;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (owner_req) begin
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
          if ((cnt_q == CntMax) && win_any) begin
            grant_d   = win_oh;
            idx_d     = win_idx;
            last_d    = win_idx;
            cnt_d     = '0;
            preempt_d = 1'b1;
          end else if (cnt_q != CntMax) begin
            cnt_d = CntW'(cnt_q + CntW'(1));
          end
`endif
        end else if (win_any) begin
          grant_d = win_oh;
          idx_d   = win_idx;
          last_d  = win_idx;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == BUSY);
  end

  assign grant_out   = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
  assign preempt     = preempt_q;
`else
  assign preempt     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (NumReq=4; MaxHold=4 when the hold limit is compiled in).
module tb_rr_lock_arbiter;

  logic       clk;
  logic       rstN;
  logic [3:0] req_in;
  logic [3:0] grant_out;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
  rr_lock_arbiter #(.NumReq(4), .MaxHold(4)) dut (
`else
  rr_lock_arbiter #(.NumReq(4)) dut (
`endif
    .clk        (clk),
    .rstN       (rstN),
    .req_in     (req_in),
    .grant_out  (grant_out),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One active edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp_oh, input logic [1:0] exp_idx);
    check({tag, ".grant"}, 32'(grant_out), 32'(exp_oh));
    check({tag, ".valid"}, 32'(grant_valid), 32'(exp_oh != 4'b0));
    check({tag, ".idx"},   32'(grant_idx), 32'(exp_idx));
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [3:0] one;
    rstN   = 1'b0;
    req_in = 4'b0000;
    repeat (2) @(negedge clk);
    check_grant("reset", 4'b0000, 2'd0);
    check("reset.preempt", 32'(preempt), 32'd0);
    rstN = 1'b1;

    // requester 0 has first priority after reset, but only 1 and 3 request
    req_in = 4'b1010;
    step();
    check_grant("first", 4'b0010, 2'd1);

`ifndef RR_LOCK_ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 20; i++) begin
      step();
      check_grant("hold20", 4'b0010, 2'd1);
    end
`endif

    // owner 1 drops, 0 and 3 pending: search from 2 finds 3
    req_in = 4'b1001;
    step();
    check_grant("drop1", 4'b1000, 2'd3);
    req_in = 4'b0001;
    step();
    check_grant("drop3", 4'b0001, 2'd0);
    req_in = 4'b0000;
    step();
    check_grant("idle", 4'b0000, 2'd0);

    // async reset mid-grant
    req_in = 4'b0010;
    step();
    check_grant("pre_rst", 4'b0010, 2'd1);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check_grant("async_rst", 4'b0000, 2'd0);
    @(negedge clk);
    rstN   = 1'b1;
    req_in = 4'b1111;
    step();
    check_grant("post_rst", 4'b0001, 2'd0);

    // all requesting, each owner keeps grant two cycles then drops for one edge
    for (int k = 0; k < 4; k++) begin
      req_in = 4'b1111;
      step();
      one = 4'b0001 << order[k];
      check_grant("rr_hold", one, 2'(order[k]));
      req_in = 4'b1111 & ~one;
      step();
      one = 4'b0001 << order[k+1];
      check_grant("rr_next", one, 2'(order[k+1]));
    end
    req_in = 4'b0000;
    step();
    check_grant("rr_idle", 4'b0000, 2'd0);

`ifdef RR_LOCK_ARB_HOLD_LIMIT_EN
    // last owner 0, so 1 wins first; then forced alternation every 4 cycles
    req_in = 4'b0011;
    step();
    check_grant("hl_first", 4'b0010, 2'd1);
    check("hl_first.preempt", 32'(preempt), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c < 4 || c == 8) check_grant("hl_alt", 4'b0010, 2'd1);
      else                 check_grant("hl_alt", 4'b0001, 2'd0);
      check("hl_alt.preempt", 32'(preempt), 32'(c == 4 || c == 8));
    end
    req_in = 4'b0001;
    step();
    check_grant("hl_release", 4'b0001, 2'd0);
    check("hl_release.preempt", 32'(preempt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_grant("hl_alone", 4'b0001, 2'd0);
      check("hl_alone.preempt", 32'(preempt), 32'd0);
    end
    // counter saturated: a new requester preempts on the very next edge
    req_in = 4'b0011;
    step();
    check_grant("hl_sat", 4'b0010, 2'd1);
    check("hl_sat.preempt", 32'(preempt), 32'd1);
    step();
    check("hl_sat.pulse", 32'(preempt), 32'd0);
`else
    req_in = 4'b0011;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check_grant("nolimit", 4'b0010, 2'd1);
      check("nolimit.preempt", 32'(preempt), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
